// File: rtl/n64a_vdeconv_if.sv
`default_nettype none
// n64a_vdeconv_if: video data bus into and out of the YPbPr-to-RGB back-converter.
// Revision: 1.0
interface n64a_vdeconv_if #(
   parameter int color_width_o = 8
);
   logic                         nEN_YPbPr;
   logic [3+3*color_width_o:0]   vdata_i;
   logic [3+3*color_width_o:0]   vdata_o;

   modport master (output nEN_YPbPr, output vdata_i, input vdata_o);
   modport slave  (input nEN_YPbPr, input vdata_i, output vdata_o);
endinterface
`default_nettype wire

// File: rtl/n64a_vdeconv.sv
`default_nettype none
// n64a_vdeconv: 4-stage offset-binary YPbPr -> RGB back-conversion with bypass; sync rides along.
// Macro VDECONV_CLAMP_EN: saturate results to [0, 2^w-1]; undefined wraps modulo 2^w.  Rev 1.0
module n64a_vdeconv #(
   parameter int color_width_o = 8,
   parameter int coeff_frac    = 20
) (
   input  wire logic       VCLK,
   input  wire logic       nRST,
   n64a_vdeconv_if.slave   bus
);
   localparam int W  = color_width_o;
   localparam int CF = coeff_frac;
   localparam int VW = 4 + 3*W;
   localparam int KW = CF + 2;
   localparam int PW = W + CF + 2;
   localparam int AW = W + CF + 3;
`ifdef VDECONV_CLAMP_EN
   localparam int RW = W + 3;
   localparam logic signed [RW-1:0] C_MAX = {3'b000, {W{1'b1}}};
`else
   localparam int RW = W;
`endif

   // Coefficients are unsigned, zero-extended by one bit so they multiply as signed.
   localparam logic signed [KW-1:0] C_KR  = KW'(1470104);
   localparam logic signed [KW-1:0] C_KGB = KW'(360858);
   localparam logic signed [KW-1:0] C_KGR = KW'(748828);
   localparam logic signed [KW-1:0] C_KB  = KW'(1858077);
   localparam logic signed [W:0]    C_OFF = {2'b01, {(W-1){1'b0}}};
   localparam logic signed [AW-1:0] C_RND = {{(AW-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};

   logic                  r0_byp, r1_byp, r2_byp;
   logic [VW-1:0]         r0_vd, r1_vd, r2_vd, r3_vd;
   logic signed [W:0]     r0_cr, r0_cb;
   logic signed [PW-1:0]  r1_kr, r1_kgb, r1_kgr, r1_kb;
   logic signed [RW-1:0]  r2_r, r2_g, r2_b;

   logic signed [W:0]     w_cr, w_cb;
   logic signed [AW-1:0]  w_yx;
   logic signed [RW-1:0]  w_r, w_g, w_b;

   function automatic logic [W-1:0] f_range(input logic signed [RW-1:0] v);
      logic [W-1:0] res;
`ifdef VDECONV_CLAMP_EN
      if (v < 0)
         res = '0;
      else if (v > C_MAX)
         res = '1;
      else
         res = v[W-1:0];
`else
      res = v;
`endif
      return res;
   endfunction

   assign w_cr = $signed({1'b0, bus.vdata_i[3*W-1 -: W]}) - C_OFF;
   assign w_cb = $signed({1'b0, bus.vdata_i[W-1:0]}) - C_OFF;

   // Y aligned to the coefficient scale; the shift right by CF drops the fraction after rounding.
   assign w_yx = {3'b000, r1_vd[2*W-1 -: W], {CF{1'b0}}};
   assign w_r  = RW'((w_yx + AW'(r1_kr) + C_RND) >>> CF);
   assign w_g  = RW'((w_yx - AW'(r1_kgb) - AW'(r1_kgr) + C_RND) >>> CF);
   assign w_b  = RW'((w_yx + AW'(r1_kb) + C_RND) >>> CF);

   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         r0_byp <= 1'b0;
         r1_byp <= 1'b0;
         r2_byp <= 1'b0;
         r0_vd  <= '0;
         r1_vd  <= '0;
         r2_vd  <= '0;
         r3_vd  <= '0;
         r0_cr  <= '0;
         r0_cb  <= '0;
         r1_kr  <= '0;
         r1_kgb <= '0;
         r1_kgr <= '0;
         r1_kb  <= '0;
         r2_r   <= '0;
         r2_g   <= '0;
         r2_b   <= '0;
      end else begin
         r0_byp <= bus.nEN_YPbPr;
         r0_vd  <= bus.vdata_i;
         r0_cr  <= w_cr;
         r0_cb  <= w_cb;

         r1_byp <= r0_byp;
         r1_vd  <= r0_vd;
         r1_kr  <= PW'(r0_cr) * PW'(C_KR);
         r1_kgb <= PW'(r0_cb) * PW'(C_KGB);
         r1_kgr <= PW'(r0_cr) * PW'(C_KGR);
         r1_kb  <= PW'(r0_cb) * PW'(C_KB);

         r2_byp <= r1_byp;
         r2_vd  <= r1_vd;
         r2_r   <= w_r;
         r2_g   <= w_g;
         r2_b   <= w_b;

         r3_vd  <= r2_byp ? r2_vd
                          : {r2_vd[VW-1 -: 4], f_range(r2_r), f_range(r2_g), f_range(r2_b)};
      end
   end

   assign bus.vdata_o = r3_vd;
endmodule
`default_nettype wire

// File: tb/tb_n64a_vdeconv.sv
`default_nettype none
// tb_n64a_vdeconv: directed scoreboard bench for the YPbPr-to-RGB back-converter.
// Revision: 1.0
module tb_n64a_vdeconv;
   localparam int W  = 8;
   localparam int VW = 4 + 3*W;

   typedef struct {
      logic [VW-1:0] vd;
      string         tag;
   } exp_t;

   logic VCLK = 1'b0;
   logic nRST = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   n64a_vdeconv_if #(.color_width_o(W)) bus ();

   n64a_vdeconv #(.color_width_o(W), .coeff_frac(20)) dut (
      .VCLK (VCLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 VCLK = ~VCLK;

   function automatic logic [7:0] rng(input longint v);
      logic [63:0] t;
      t = v;
`ifdef VDECONV_CLAMP_EN
      if (v < 0)
         t = 0;
      else if (v > 255)
         t = 255;
`endif
      return t[7:0];
   endfunction

   function automatic logic [VW-1:0] model(input logic byp, input logic [VW-1:0] vd);
      longint y, cr, cb, r, g, b;
      if (byp)
         return vd;
      cr = longint'(vd[23:16]) - 128;
      y  = longint'(vd[15:8]);
      cb = longint'(vd[7:0]) - 128;
      r  = ((y <<< 20) + 1470104 * cr + 524288) >>> 20;
      g  = ((y <<< 20) - 360858 * cb - 748828 * cr + 524288) >>> 20;
      b  = ((y <<< 20) + 1858077 * cb + 524288) >>> 20;
      return {vd[27:24], rng(r), rng(g), rng(b)};
   endfunction

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: compare the output due now, then drive a new sample and queue its expectation.
   task automatic step(input logic rst_n, input logic byp, input logic [VW-1:0] vd,
                       input logic [VW-1:0] ex, input string tag);
      exp_t e;
      @(negedge VCLK);
      if (q.size() >= 4) begin
         e = q.pop_front();
         check(e.tag, bus.vdata_o, e.vd);
      end
      nRST          = rst_n;
      bus.nEN_YPbPr = byp;
      bus.vdata_i   = vd;
      if (!rst_n) begin
         foreach (q[i]) begin
            q[i].vd  = '0;
            q[i].tag = "rst_flush";
         end
         e.vd  = '0;
         e.tag = "rst_zero";
      end else begin
         e.vd  = ex;
         e.tag = tag;
      end
      q.push_back(e);
   endtask

   task automatic stepm(input logic byp, input logic [VW-1:0] vd, input string tag);
      step(1'b1, byp, vd, model(byp, vd), tag);
   endtask

   initial begin
      logic [VW-1:0] vd;
      exp_t e;
      bus.nEN_YPbPr = 1'b0;
      bus.vdata_i   = '0;

      @(negedge VCLK);
      check("reset_state", bus.vdata_o, '0);

      step(1'b0, 1'b0, '0, '0, "rst");
      step(1'b0, 1'b1, '0, '0, "rst");

      // Directed conversions with hand-computed results
      step(1'b1, 1'b0, {4'hA, 8'd128, 8'd128, 8'd128}, {4'hA, 8'd128, 8'd128, 8'd128}, "grey");
      step(1'b1, 1'b0, {4'h5, 8'd128, 8'd255, 8'd128}, {4'h5, 8'd255, 8'd255, 8'd255}, "white");
      step(1'b1, 1'b0, {4'h3, 8'd255, 8'd76, 8'd85},   {4'h3, 8'd254, 8'd0, 8'd0},     "red");
`ifdef VDECONV_CLAMP_EN
      step(1'b1, 1'b0, {4'hC, 8'd255, 8'd255, 8'd128}, {4'hC, 8'd255, 8'd164, 8'd255}, "oog_hi");
      step(1'b1, 1'b0, {4'h6, 8'd0, 8'd0, 8'd128},     {4'h6, 8'd0, 8'd91, 8'd0},      "oog_lo");
`else
      step(1'b1, 1'b0, {4'hC, 8'd255, 8'd255, 8'd128}, {4'hC, 8'd177, 8'd164, 8'd255}, "oog_hi");
      step(1'b1, 1'b0, {4'h6, 8'd0, 8'd0, 8'd128},     {4'h6, 8'd77, 8'd91, 8'd0},     "oog_lo");
`endif
      step(1'b1, 1'b1, {4'h9, 8'd255, 8'd76, 8'd85},   {4'h9, 8'd255, 8'd76, 8'd85},   "bypass");

      // Ramp with the mode flipping every 3 samples
      for (int i = 0; i < 18; i++) begin
         vd = {4'(i), 8'(i * 13), 8'(i * 29 + 7), 8'(255 - i * 11)};
         stepm(1'((i / 3) % 2), vd, $sformatf("ramp%0d", i));
      end

      // Reset mid-stream: in-flight samples vanish, first sample after release is converted
      stepm(1'b0, {4'h7, 8'd200, 8'd90, 8'd40}, "pre_rst0");
      stepm(1'b1, {4'h8, 8'd10, 8'd20, 8'd30},  "pre_rst1");
      step(1'b0, 1'b1, {4'hF, 8'd1, 8'd2, 8'd3}, '0, "rst_mid");
      step(1'b1, 1'b0, {4'hA, 8'd128, 8'd128, 8'd128}, {4'hA, 8'd128, 8'd128, 8'd128}, "post_rst");
      stepm(1'b1, {4'h2, 8'd33, 8'd44, 8'd55},  "post_rst_byp");
      stepm(1'b0, {4'h4, 8'd60, 8'd150, 8'd220}, "post_rst_cnv");

      for (int i = 0; i < 4; i++) begin
         @(negedge VCLK);
         bus.vdata_i = '0;
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, bus.vdata_o, e.vd);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
